// File: rtl/pipe_entry_arbiter.sv
// Round-robin 2:1 arbiter feeding the entry stage of the async stage_control pipeline.
// Both requesters and the downstream stage use a 4-phase valid/ack handshake.
module pipe_entry_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RTZ  = 2'd3;

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [15:0] wdog;
    logic [15:0] wdog_inc;
    logic        last_ptr;
    logic        owner;
    logic        pick;
    logic        req_k;

    // pick: side that wins in IDLE; req_k: request line of the current owner
    always_comb begin
        pick     = (req0 && req1) ? ~last_ptr : req1;
        req_k    = owner ? req1 : req0;
        wdog_inc = wdog + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            wdog        <= '0;
            last_ptr    <= 1'b1;
            owner       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state     <= ST_SEND;
                        owner     <= pick;
                        last_ptr  <= pick;
                        grant     <= pick ? 2'b10 : 2'b01;
                        data_out  <= pick ? data1 : data0;
                        valid_out <= 1'b1;
                        busy      <= 1'b1;
                        wdog      <= '0;
                    end
                end
                ST_SEND: begin
                    if (ack_in) begin
                        state <= ST_HOLD;
                        wdog  <= '0;
                        if (owner) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                    end else if (wdog != WDOG_LIMIT) begin
                        // counter saturates at the limit; the flag stays set until reset
                        wdog <= wdog_inc;
                        if (wdog_inc == WDOG_LIMIT) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!req_k) begin
                        state     <= ST_RTZ;
                        valid_out <= 1'b0;
                        ack0      <= 1'b0;
                        ack1      <= 1'b0;
                    end
                end
                ST_RTZ: begin
                    if (!ack_in) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_entry_arbiter.sv
// Scoreboard bench for pipe_entry_arbiter: directed scenarios plus randomized
// requesters and an async-stage model, checked by an independent negedge monitor.
module tb_pipe_entry_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, ack_in;
    logic [7:0] data0, data1;
    logic       ack0, ack1, valid_out, busy, err_timeout;
    logic [7:0] data_out;
    logic [1:0] grant;

    always #5 clk = ~clk;

    pipe_entry_arbiter #(
        .DATA_W (8),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .data0      (data0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .ack1       (ack1),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .ack_in     (ack_in),
        .grant      (grant),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    typedef struct {
        string name;
        int    sel;
        int    val;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   q0[$];
    int   q1[$];
    exp_t exq[$];
    int   hist = 0;
    int   n0 = 0, n1 = 0, sdelay = 0;

    bit       last_side = 1'b1;
    bit       cur_side  = 1'b0;
    bit       exp_side;
    bit       p_r0 = 0, p_r1 = 0, p_ack_in = 0, p_busy = 0, p_valid = 0, p_rst = 0, p_kack = 0;
    logic [7:0] p_data = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input string n, input int sel, input int val);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.val  = val;
        exq.push_back(e);
    endtask

    function automatic int sel_value(input int sel);
        case (sel)
            0:       return int'(grant);
            1:       return int'(valid_out);
            2:       return int'(ack0);
            3:       return int'(ack1);
            4:       return int'(data_out);
            5:       return int'(busy);
            6:       return int'(err_timeout);
            7:       return q0.size() + q1.size();
            default: return hist;
        endcase
    endfunction

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: directed expectations, grant/data scoreboard and handshake ordering
    always @(negedge clk) begin : monitor
        exp_t e;
        int   w;
        while (exq.size() > 0) begin
            e = exq.pop_front();
            check(e.name, sel_value(e.sel), e.val);
        end
        if (rst_n && p_rst) begin
            if (busy && !p_busy) begin
                exp_side  = (p_r0 && p_r1) ? ~last_side : p_r1;
                last_side = exp_side;
                cur_side  = exp_side;
                check("grant_owner", int'(grant), exp_side ? 2 : 1);
                if (exp_side) begin
                    if (q1.size() == 0) check("dup_word1", int'(data_out), -1);
                    else begin
                        w = q1.pop_front();
                        check("data_word1", int'(data_out), w);
                    end
                end else begin
                    if (q0.size() == 0) check("dup_word0", int'(data_out), -1);
                    else begin
                        w = q0.pop_front();
                        check("data_word0", int'(data_out), w);
                    end
                end
                hist = (hist << 8) | int'(data_out);
            end
            if (busy && p_busy) begin
                check("data_hold", int'(data_out), int'(p_data));
                check("ack_other", int'(cur_side ? ack0 : ack1), 0);
            end
            if ((cur_side ? ack1 : ack0) && !p_kack)
                check("ack_after_ack_in", int'(p_ack_in), 1);
            if (!valid_out && p_valid)
                check("valid_fall_after_req_low", int'(cur_side ? p_r1 : p_r0), 0);
        end
        if (!rst_n) last_side = 1'b1;
        p_r0     = req0;
        p_r1     = req1;
        p_ack_in = ack_in;
        p_busy   = busy;
        p_valid  = valid_out;
        p_rst    = rst_n;
        p_data   = data_out;
        p_kack   = cur_side ? ack1 : ack0;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        ack_in = 1'b0;
        sdelay = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One cycle of requester and downstream-stage behaviour
    task automatic auto_cycle(input bit rnd, input bit gen0, input bit gen1);
        int d;
        if (!req0 && !ack0 && gen0 && (!rnd || $urandom_range(0, 2) != 0)) begin
            d = rnd ? int'($urandom_range(0, 255)) : 'h11;
            data0 = 8'(d);
            req0  = 1'b1;
            q0.push_back(d);
            n0++;
        end else if (req0 && ack0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            req0 = 1'b0;
        end
        if (!req1 && !ack1 && gen1 && (!rnd || $urandom_range(0, 2) != 0)) begin
            d = rnd ? int'($urandom_range(0, 255)) : 'h22;
            data1 = 8'(d);
            req1  = 1'b1;
            q1.push_back(d);
            n1++;
        end else if (req1 && ack1 && (!rnd || $urandom_range(0, 1) == 1)) begin
            req1 = 1'b0;
        end
        if (valid_out != ack_in) begin
            if (sdelay == 0) begin
                ack_in = valid_out;
                sdelay = rnd ? int'($urandom_range(0, 2)) : 0;
            end else begin
                sdelay--;
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; ack_in = 1'b0;
        data0 = '0; data1 = '0;
        tick();
        tick();
        expect_sig("rst_grant", 0, 0);
        expect_sig("rst_valid", 1, 0);
        expect_sig("rst_ack0", 2, 0);
        expect_sig("rst_ack1", 3, 0);
        expect_sig("rst_data", 4, 0);
        expect_sig("rst_busy", 5, 0);
        expect_sig("rst_err", 6, 0);

        // single transfer from requester 0, stage acks two cycles late
        rst_n = 1'b1;
        req0 = 1'b1; data0 = 8'hA5; q0.push_back('hA5);
        tick();
        expect_sig("single_valid", 1, 1);
        expect_sig("single_grant", 0, 1);
        expect_sig("single_data", 4, 'hA5);
        expect_sig("single_busy", 5, 1);
        tick();
        tick();
        ack_in = 1'b1;
        tick();
        expect_sig("single_ack0", 2, 1);
        expect_sig("single_ack1", 3, 0);
        expect_sig("single_hold_valid", 1, 1);
        req0 = 1'b0;
        tick();
        expect_sig("single_rtz_valid", 1, 0);
        expect_sig("single_rtz_ack0", 2, 0);
        expect_sig("single_rtz_grant", 0, 1);
        ack_in = 1'b0;
        tick();
        expect_sig("single_idle_grant", 0, 0);
        expect_sig("single_idle_busy", 5, 0);

        // stray ack_in while idle
        ack_in = 1'b1;
        tick();
        tick();
        expect_sig("idle_ack_busy", 5, 0);
        expect_sig("idle_ack_valid", 1, 0);
        ack_in = 1'b0;
        tick();

        // contention with an immediate-ack stage
        do_reset();
        n0 = 0; n1 = 0;
        repeat (40) begin
            auto_cycle(1'b0, n0 < 2, n1 < 2);
            tick();
        end
        expect_sig("contention_sequence", 8, 'h11221122);
        expect_sig("contention_drained", 7, 0);

        // late request from side 1 while side 0 holds the channel
        do_reset();
        req0 = 1'b1; data0 = 8'h5A; q0.push_back('h5A);
        tick();
        expect_sig("late_grant0", 0, 1);
        ack_in = 1'b1;
        tick();
        expect_sig("late_ack0", 2, 1);
        req1 = 1'b1; data1 = 8'h6B; q1.push_back('h6B);
        tick();
        expect_sig("late_ignored_ack1", 3, 0);
        expect_sig("late_ignored_grant", 0, 1);
        req0 = 1'b0;
        tick();
        expect_sig("late_rtz_grant", 0, 1);
        expect_sig("late_rtz_valid", 1, 0);
        ack_in = 1'b0;
        tick();
        expect_sig("late_idle_grant", 0, 0);
        tick();
        expect_sig("late_grant1", 0, 2);
        expect_sig("late_data1", 4, 'h6B);
        ack_in = 1'b1;
        tick();
        expect_sig("late_ack1", 3, 1);
        req1 = 1'b0;
        tick();
        ack_in = 1'b0;
        tick();
        expect_sig("late_done_busy", 5, 0);

        // watchdog with limit 4
        do_reset();
        req1 = 1'b1; data1 = 8'h3C; q1.push_back('h3C);
        tick();
        expect_sig("to_valid", 1, 1);
        expect_sig("to_grant", 0, 2);
        tick();
        tick();
        tick();
        expect_sig("to_err_before", 6, 0);
        tick();
        expect_sig("to_err_set", 6, 1);
        expect_sig("to_valid_kept", 1, 1);
        tick();
        expect_sig("to_err_sticky", 6, 1);
        ack_in = 1'b1;
        tick();
        expect_sig("to_ack1", 3, 1);
        expect_sig("to_err_hold", 6, 1);
        req1 = 1'b0;
        tick();
        expect_sig("to_rtz_valid", 1, 0);
        ack_in = 1'b0;
        tick();
        expect_sig("to_idle_grant", 0, 0);
        expect_sig("to_err_after", 6, 1);

        // reset taken in HOLD, then contention restarts with side 0
        do_reset();
        expect_sig("to_err_cleared", 6, 0);
        req0 = 1'b1; data0 = 8'h77; q0.push_back('h77);
        for (int i = 0; i < 10 && !ack0; i++) begin
            tick();
            ack_in = valid_out;
        end
        expect_sig("reach_hold", 2, 1);
        rst_n = 1'b0; req0 = 1'b0; ack_in = 1'b0;
        tick();
        expect_sig("mid_rst_grant", 0, 0);
        expect_sig("mid_rst_valid", 1, 0);
        expect_sig("mid_rst_ack0", 2, 0);
        expect_sig("mid_rst_ack1", 3, 0);
        expect_sig("mid_rst_busy", 5, 0);
        expect_sig("mid_rst_data", 4, 0);
        rst_n = 1'b1;
        req0 = 1'b1; data0 = 8'h81; q0.push_back('h81);
        req1 = 1'b1; data1 = 8'h82; q1.push_back('h82);
        tick();
        expect_sig("post_rst_grant", 0, 1);
        repeat (30) begin
            auto_cycle(1'b0, 1'b0, 1'b0);
            tick();
        end
        expect_sig("post_rst_drained", 7, 0);
        expect_sig("post_rst_busy", 5, 0);

        // randomized traffic
        do_reset();
        repeat (10000) begin
            auto_cycle(1'b1, 1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < 200; i++) begin
            if (!busy && !req0 && !req1 && !ack_in) break;
            auto_cycle(1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_sig("rand_drained", 7, 0);
        expect_sig("rand_busy", 5, 0);
        expect_sig("rand_err", 6, 0);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
